// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-access stage
package mem_pkg;

   localparam int DEF_DEPTH       = 256;
   localparam int DEF_MEM_LATENCY = 2;
   localparam int WORD_OFFSET     = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Misaligned access or simultaneous read+write cannot be serviced.
   function automatic logic op_illegal(input logic [1:0] addr_lo,
                                       input logic       rd,
                                       input logic       wr);
      return (rd && wr) || ((rd || wr) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-addressed data memory, sync write, async read, no reset
module data_mem
   import mem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline MEM stage with multi-cycle data memory and stall handshake
module memory_access
   import mem_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic [4:0]  rd_in_mem,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic        mem_to_reg,
   output logic        stall_out,
   output logic [31:0] alu_data_out,
   output logic [31:0] dm_data_out,
   output logic [4:0]  rd_out_mem,
   output logic        reg_write_out_mem,
   output logic        mem_to_reg_out,
   output logic        mem_err
);

   localparam int IDX_W = $clog2(DEPTH);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] lat_addr;
   logic [31:0] lat_store;
   logic [4:0]  lat_rd;
   logic        lat_read;
   logic        lat_write;
   logic        lat_reg_write;
   logic        lat_mem_to_reg;

   logic             mem_we;
   logic [IDX_W-1:0] mem_idx;
   logic [31:0]      mem_rdata;
   logic             illegal;

   assign stall_out = (state == BUSY);
   assign illegal   = op_illegal(alu_result_in[1:0], mem_read, mem_write);
   // Upper address bits are dropped so accesses wrap modulo DEPTH.
   assign mem_idx   = lat_addr[IDX_W+WORD_OFFSET-1:WORD_OFFSET];
   // Write only fires on the completion edge; reset forces IDLE, dropping a pending store.
   assign mem_we    = (state == BUSY) && (cnt == 4'd0) && lat_write;

   data_mem #(
      .DEPTH(DEPTH),
      .IDX_W(IDX_W)
   ) u_data_mem (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_idx),
      .wdata(lat_store),
      .rdata(mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         cnt               <= 4'd0;
         lat_addr          <= 32'd0;
         lat_store         <= 32'd0;
         lat_rd            <= 5'd0;
         lat_read          <= 1'b0;
         lat_write         <= 1'b0;
         lat_reg_write     <= 1'b0;
         lat_mem_to_reg    <= 1'b0;
         alu_data_out      <= 32'd0;
         dm_data_out       <= 32'd0;
         rd_out_mem        <= 5'd0;
         reg_write_out_mem <= 1'b0;
         mem_to_reg_out    <= 1'b0;
         mem_err           <= 1'b0;
      end else begin
         mem_err <= 1'b0;
         case (state)
            IDLE: begin
               if (!valid_in) begin
                  reg_write_out_mem <= 1'b0;
               end else if (illegal) begin
                  reg_write_out_mem <= 1'b0;
                  mem_err           <= 1'b1;
               end else if (mem_read || mem_write) begin
                  lat_addr          <= alu_result_in;
                  lat_store         <= store_data_in;
                  lat_rd            <= rd_in_mem;
                  lat_read          <= mem_read;
                  lat_write         <= mem_write;
                  lat_reg_write     <= reg_write;
                  lat_mem_to_reg    <= mem_to_reg;
                  reg_write_out_mem <= 1'b0;
                  cnt               <= 4'(MEM_LATENCY - 1);
                  state             <= BUSY;
               end else begin
                  alu_data_out      <= alu_result_in;
                  rd_out_mem        <= rd_in_mem;
                  reg_write_out_mem <= reg_write;
                  mem_to_reg_out    <= mem_to_reg;
               end
            end
            BUSY: begin
               if (cnt != 4'd0) begin
                  cnt               <= cnt - 4'd1;
                  reg_write_out_mem <= 1'b0;
               end else begin
                  state <= IDLE;
                  if (lat_read) begin
                     dm_data_out       <= mem_rdata;
                     alu_data_out      <= lat_addr;
                     rd_out_mem        <= lat_rd;
                     reg_write_out_mem <= lat_reg_write;
                     mem_to_reg_out    <= lat_mem_to_reg;
                  end else begin
                     reg_write_out_mem <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed self-checking bench for memory_access
module tb_memory_access;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [31:0] alu_result_in;
   logic [31:0] store_data_in;
   logic [4:0]  rd_in_mem;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        mem_to_reg;
   logic        stall_out;
   logic [31:0] alu_data_out;
   logic [31:0] dm_data_out;
   logic [4:0]  rd_out_mem;
   logic        reg_write_out_mem;
   logic        mem_to_reg_out;
   logic        mem_err;

   int total = 0;
   int bad   = 0;
   int stalls;

   memory_access #(
      .DEPTH(256),
      .MEM_LATENCY(2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .alu_result_in    (alu_result_in),
      .store_data_in    (store_data_in),
      .rd_in_mem        (rd_in_mem),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .reg_write        (reg_write),
      .mem_to_reg       (mem_to_reg),
      .stall_out        (stall_out),
      .alu_data_out     (alu_data_out),
      .dm_data_out      (dm_data_out),
      .rd_out_mem       (rd_out_mem),
      .reg_write_out_mem(reg_write_out_mem),
      .mem_to_reg_out   (mem_to_reg_out),
      .mem_err          (mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one op at a negedge, accept it, then count stalled cycles (bounded).
   task automatic do_op(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic rw, input logic m2r,
                        output int n_stall);
      @(negedge clk);
      valid_in      = 1'b1;
      alu_result_in = addr;
      store_data_in = sd;
      rd_in_mem     = rd;
      mem_read      = mr;
      mem_write     = mw;
      reg_write     = rw;
      mem_to_reg    = m2r;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      n_stall  = 0;
      while (stall_out && n_stall < 20) begin
         n_stall++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset         = 1'b0;
      valid_in      = 1'b0;
      alu_result_in = 32'd0;
      store_data_in = 32'd0;
      rd_in_mem     = 5'd0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      #12;
      check("rst_stall", stall_out, 0);
      check("rst_alu", alu_data_out, 0);
      check("rst_dm", dm_data_out, 0);
      check("rst_rw", reg_write_out_mem, 0);
      check("rst_err", mem_err, 0);
      @(negedge clk);
      reset = 1'b1;

      do_op(32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      check("st_stall", stalls, 2);
      check("st_rw", reg_write_out_mem, 0);

      do_op(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      check("ld_stall", stalls, 2);
      check("ld_dm", dm_data_out, 32'hDEADBEEF);
      check("ld_rd", rd_out_mem, 5);
      check("ld_rw", reg_write_out_mem, 1);
      check("ld_m2r", mem_to_reg_out, 1);
      check("ld_alu", alu_data_out, 32'h10);

      do_op(32'h1234, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, stalls);
      check("alu_stall", stalls, 0);
      check("alu_data", alu_data_out, 32'h1234);
      check("alu_rd", rd_out_mem, 3);
      check("alu_rw", reg_write_out_mem, 1);
      check("alu_dm_hold", dm_data_out, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      check("bubble_rw", reg_write_out_mem, 0);
      check("bubble_alu", alu_data_out, 32'h1234);

      do_op(32'h13, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      check("mis_stall", stalls, 0);
      check("mis_err", mem_err, 1);
      check("mis_rw", reg_write_out_mem, 0);
      @(posedge clk);
      #1;
      check("mis_err_pulse", mem_err, 0);

      do_op(32'h400, 32'h55, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      check("wrap_st_stall", stalls, 2);
      do_op(32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      check("wrap_dm", dm_data_out, 32'h55);
      check("wrap_rd", rd_out_mem, 7);

      do_op(32'h20, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, stalls);
      check("pre_st_stall", stalls, 2);
      @(negedge clk);
      valid_in      = 1'b1;
      alu_result_in = 32'h20;
      store_data_in = 32'h11111111;
      mem_read      = 1'b0;
      mem_write     = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      check("busy_before_rst", stall_out, 1);
      reset = 1'b0;
      #1;
      check("arst_stall", stall_out, 0);
      check("arst_dm", dm_data_out, 0);
      check("arst_rd", rd_out_mem, 0);
      check("arst_m2r", mem_to_reg_out, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      do_op(32'h20, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      check("dropped_store", dm_data_out, 32'hCAFEF00D);

      do_op(32'h10, 32'h99, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, stalls);
      check("rw_stall", stalls, 0);
      check("rw_err", mem_err, 1);
      check("rw_rwout", reg_write_out_mem, 0);
      do_op(32'h10, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, stalls);
      check("rw_mem_kept", dm_data_out, 32'hDEADBEEF);
      check("rw_err_clear", mem_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter DEPTH, default 256: data-memory words; power of two.
REQ-002 SHALL have parameter MEM_LATENCY, default 2: memory-op latency in cycles; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port valid_in, input, 1: EX/MEM slot holds a real instruction.
REQ-006 SHALL have port alu_result_in, input, 32: ALU result; also the byte address for loads and stores.
REQ-007 SHALL have port store_data_in, input, 32: rs2 data for stores.
REQ-008 SHALL have port rd_in_mem, input, 5: destination register.
REQ-009 SHALL have ports mem_read, mem_write, reg_write, mem_to_reg, input, 1 each: EX/MEM control bits.
REQ-010 SHALL have port stall_out, input-side handshake, output, 1: upstream holds its inputs while high.
REQ-011 SHALL have ports alu_data_out and dm_data_out, output, 32 each: to write-back.
REQ-012 SHALL have ports rd_out_mem (output, 5), reg_write_out_mem (output, 1) and mem_to_reg_out (output, 1): to write-back.
REQ-013 SHALL have port mem_err, output, 1: one-cycle pulse on an illegal memory op.

Function
REQ-014 SHALL implement FSM states IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-015 SHALL treat an op as accepted at a posedge when state is IDLE and valid_in is 1.
REQ-016 SHALL treat valid_in=0 in IDLE as a bubble: reg_write_out_mem<=0, mem_err<=0, all other outputs hold.
REQ-017 Non-memory op (mem_read=mem_write=0) SHALL register outputs at the accepting edge (1-edge latency):
- alu_data_out<=alu_result_in;
- rd_out_mem, reg_write_out_mem, mem_to_reg_out <= their inputs.
REQ-018 An accepted legal memory op SHALL latch all inputs, enter BUSY with cnt<=MEM_LATENCY-1, and drive reg_write_out_mem<=0.
REQ-019 In BUSY with cnt!=0, SHALL decrement cnt and keep reg_write_out_mem=0.
REQ-020 In BUSY with cnt==0, SHALL complete the op and return to IDLE; result is registered at acceptance edge + MEM_LATENCY.
- Load completion: dm_data_out<=mem[index]; alu_data_out, rd_out_mem, reg_write_out_mem, mem_to_reg_out <= latched values.
- Store completion: mem[index]<=latched store data; reg_write_out_mem<=0.
REQ-021 stall_out SHALL equal (state==BUSY), combinationally; inputs SHALL be ignored while BUSY.
REQ-022 Memory index SHALL be address[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so accesses wrap modulo DEPTH.
REQ-023 An op is illegal when address[1:0]!=0 with mem_read or mem_write set, or when mem_read and mem_write are both set.
REQ-024 An illegal op SHALL cause no memory access, stay in IDLE, drive reg_write_out_mem<=0 and pulse mem_err for one cycle.
REQ-025 dm_data_out SHALL change only on load completion; it holds otherwise.

Reset
REQ-026 reset low SHALL immediately:
- force state IDLE, cnt 0, stall_out 0;
- zero all outputs;
- drop a pending store (memory unchanged).
REQ-027 Memory array contents SHALL NOT be reset.

Structure
REQ-028 A shared package mem_pkg SHALL hold the state enum, DEPTH and MEM_LATENCY defaults, and the word-offset constant 2.
REQ-029 Storage SHALL be a sub-module data_mem with a synchronous write port and a combinational read port; FSM and output registers stay in memory_access.

Verification
REQ-030 Bench SHALL cover, with MEM_LATENCY=2:
- Store 0xDEADBEEF at addr 0x10, then load addr 0x10 into rd=5 -> dm_data_out=0xDEADBEEF, rd_out_mem=5, reg_write_out_mem=1 at load-accept edge +2; stall_out high exactly 2 cycles per op.
- Non-memory op, alu_result_in=0x1234, rd=3 -> next edge alu_data_out=0x1234, reg_write_out_mem=1, stall_out stays 0.
- Load from addr 0x13 -> mem_err pulses 1 cycle, reg_write_out_mem=0, no stall.
- Store 0x55 at addr 0x400 (DEPTH=256), then load addr 0x0 -> reads 0x55 (wrap).
- Store to addr 0x20, reset asserted low during BUSY -> outputs 0 immediately; a later load of 0x20 returns the prior value.
- mem_read=mem_write=1 -> mem_err pulse, memory unchanged.
